// File: rtl/sram_sched_pkg.sv
// rtl/sram_sched_pkg.sv - shared widths, request/tag types and requester ids for the SRAM scheduler
package sram_sched_pkg;

    localparam int ADDR_WIDTH = 8;
    localparam int DATA_WIDTH = 32;
    localparam int NUM_WMASKS = DATA_WIDTH / 8;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    typedef struct packed {
        logic                  we;
        logic [NUM_WMASKS-1:0] wmask;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } req_t;

    typedef struct packed {
        logic valid;
        logic req_id;
    } tag_t;

endpackage

// File: rtl/sram_sched_arb.sv
// rtl/sram_sched_arb.sv - grant and port selection for two requesters plus the write-write round-robin flop
module sram_sched_arb
    import sram_sched_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_a_valid,
    input  logic                  i_a_we,
    input  logic [ADDR_WIDTH-1:0] i_a_addr,
    input  logic                  i_b_valid,
    input  logic                  i_b_we,
    input  logic [ADDR_WIDTH-1:0] i_b_addr,
    output logic                  o_a_ready,
    output logic                  o_b_ready,
    output logic                  o_p0_en,
    output logic                  o_p0_sel,
    output logic                  o_p1_en,
    output logic                  o_p1_sel
);

    logic r_rr;
    logic w_a_wr;
    logic w_a_rd;
    logic w_b_wr;
    logic w_b_rd;
    logic w_same;
    logic w_a_grant;
    logic w_b_grant;

    assign w_a_wr = i_a_valid & i_a_we;
    assign w_a_rd = i_a_valid & ~i_a_we;
    assign w_b_wr = i_b_valid & i_b_we;
    assign w_b_rd = i_b_valid & ~i_b_we;
    assign w_same = (i_a_addr == i_b_addr);

    always_comb begin
        w_a_grant = 1'b0;
        w_b_grant = 1'b0;
        o_p0_en   = 1'b0;
        o_p0_sel  = REQ_A;
        o_p1_en   = 1'b0;
        o_p1_sel  = REQ_A;
        if (w_a_wr && w_b_wr) begin
            o_p0_en   = 1'b1;
            o_p0_sel  = r_rr;
            w_a_grant = (r_rr == REQ_A);
            w_b_grant = (r_rr == REQ_B);
        end else if (w_a_wr) begin
            w_a_grant = 1'b1;
            o_p0_en   = 1'b1;
            // A same-address read would race the write inside the macro
            if (w_b_rd && !w_same) begin
                w_b_grant = 1'b1;
                o_p1_en   = 1'b1;
                o_p1_sel  = REQ_B;
            end
        end else if (w_b_wr) begin
            w_b_grant = 1'b1;
            o_p0_en   = 1'b1;
            o_p0_sel  = REQ_B;
            if (w_a_rd && !w_same) begin
                w_a_grant = 1'b1;
                o_p1_en   = 1'b1;
            end
        end else if (w_a_rd && w_b_rd) begin
            w_a_grant = 1'b1;
            w_b_grant = 1'b1;
            o_p0_en   = 1'b1;
            o_p1_en   = 1'b1;
            o_p1_sel  = REQ_B;
        end else if (w_a_rd || w_b_rd) begin
            w_a_grant = w_a_rd;
            w_b_grant = w_b_rd;
            o_p1_en   = 1'b1;
            o_p1_sel  = w_b_rd ? REQ_B : REQ_A;
        end
    end

    assign o_a_ready = w_a_grant | ~i_a_valid;
    assign o_b_ready = w_b_grant | ~i_b_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr <= REQ_A;
        end else if (w_a_wr && w_b_wr) begin
            r_rr <= ~r_rr;
        end
    end

endmodule

// File: rtl/sram_dual_port_scheduler.sv
// rtl/sram_dual_port_scheduler.sv - shares a 1RW1R SRAM macro between requesters A and B with 2-cycle reads
module sram_dual_port_scheduler
    import sram_sched_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic                  a_we,
    input  logic [NUM_WMASKS-1:0] a_wmask,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_rsp_valid,
    output logic [DATA_WIDTH-1:0] a_rsp_data,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic                  b_we,
    input  logic [NUM_WMASKS-1:0] b_wmask,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_rsp_valid,
    output logic [DATA_WIDTH-1:0] b_rsp_data,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0,
    output logic                  sram_csb1,
    output logic [ADDR_WIDTH-1:0] sram_addr1,
    input  logic [DATA_WIDTH-1:0] sram_dout1
);

    req_t                  w_a_req;
    req_t                  w_b_req;
    req_t                  w_p0_req;
    logic [ADDR_WIDTH-1:0] w_p1_addr;
    logic                  w_p0_en;
    logic                  w_p0_sel;
    logic                  w_p1_en;
    logic                  w_p1_sel;
    logic                  w_a_hit0;
    logic                  w_a_hit1;
    logic                  w_b_hit0;
    logic                  w_b_hit1;

    logic                  r_csb0;
    logic                  r_web0;
    logic [NUM_WMASKS-1:0] r_wmask0;
    logic [ADDR_WIDTH-1:0] r_addr0;
    logic [DATA_WIDTH-1:0] r_din0;
    logic                  r_csb1;
    logic [ADDR_WIDTH-1:0] r_addr1;
    tag_t                  r_tag0_s1;
    tag_t                  r_tag0_s2;
    tag_t                  r_tag1_s1;
    tag_t                  r_tag1_s2;
    logic                  r_a_rsp_valid;
    logic [DATA_WIDTH-1:0] r_a_rsp_data;
    logic                  r_b_rsp_valid;
    logic [DATA_WIDTH-1:0] r_b_rsp_data;

    sram_sched_arb u_arb (
        .clk       (clk),
        .rst       (rst),
        .i_a_valid (a_valid),
        .i_a_we    (a_we),
        .i_a_addr  (a_addr),
        .i_b_valid (b_valid),
        .i_b_we    (b_we),
        .i_b_addr  (b_addr),
        .o_a_ready (a_ready),
        .o_b_ready (b_ready),
        .o_p0_en   (w_p0_en),
        .o_p0_sel  (w_p0_sel),
        .o_p1_en   (w_p1_en),
        .o_p1_sel  (w_p1_sel)
    );

    assign w_a_req   = '{we: a_we, wmask: a_wmask, addr: a_addr, wdata: a_wdata};
    assign w_b_req   = '{we: b_we, wmask: b_wmask, addr: b_addr, wdata: b_wdata};
    assign w_p0_req  = (w_p0_sel == REQ_B) ? w_b_req : w_a_req;
    assign w_p1_addr = (w_p1_sel == REQ_B) ? b_addr : a_addr;

    assign w_a_hit0 = r_tag0_s2.valid & (r_tag0_s2.req_id == REQ_A);
    assign w_a_hit1 = r_tag1_s2.valid & (r_tag1_s2.req_id == REQ_A);
    assign w_b_hit0 = r_tag0_s2.valid & (r_tag0_s2.req_id == REQ_B);
    assign w_b_hit1 = r_tag1_s2.valid & (r_tag1_s2.req_id == REQ_B);

    // Stage-2 tags line up with macro dout, which settles one cycle after the pins are sampled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_csb0        <= 1'b1;
            r_web0        <= 1'b1;
            r_wmask0      <= '0;
            r_addr0       <= '0;
            r_din0        <= '0;
            r_csb1        <= 1'b1;
            r_addr1       <= '0;
            r_tag0_s1     <= '0;
            r_tag0_s2     <= '0;
            r_tag1_s1     <= '0;
            r_tag1_s2     <= '0;
            r_a_rsp_valid <= 1'b0;
            r_a_rsp_data  <= '0;
            r_b_rsp_valid <= 1'b0;
            r_b_rsp_data  <= '0;
        end else begin
            r_csb0 <= ~w_p0_en;
            r_web0 <= ~(w_p0_en & w_p0_req.we);
            if (w_p0_en) begin
                r_addr0 <= w_p0_req.addr;
            end
            if (w_p0_en && w_p0_req.we) begin
                r_wmask0 <= w_p0_req.wmask;
                r_din0   <= w_p0_req.wdata;
            end
            r_csb1 <= ~w_p1_en;
            if (w_p1_en) begin
                r_addr1 <= w_p1_addr;
            end
            r_tag0_s1     <= '{valid: w_p0_en & ~w_p0_req.we, req_id: w_p0_sel};
            r_tag1_s1     <= '{valid: w_p1_en, req_id: w_p1_sel};
            r_tag0_s2     <= r_tag0_s1;
            r_tag1_s2     <= r_tag1_s1;
            r_a_rsp_valid <= w_a_hit0 | w_a_hit1;
            r_b_rsp_valid <= w_b_hit0 | w_b_hit1;
            if (w_a_hit0) begin
                r_a_rsp_data <= sram_dout0;
            end else if (w_a_hit1) begin
                r_a_rsp_data <= sram_dout1;
            end
            if (w_b_hit0) begin
                r_b_rsp_data <= sram_dout0;
            end else if (w_b_hit1) begin
                r_b_rsp_data <= sram_dout1;
            end
        end
    end

    assign sram_csb0   = r_csb0;
    assign sram_web0   = r_web0;
    assign sram_wmask0 = r_wmask0;
    assign sram_addr0  = r_addr0;
    assign sram_din0   = r_din0;
    assign sram_csb1   = r_csb1;
    assign sram_addr1  = r_addr1;
    assign a_rsp_valid = r_a_rsp_valid;
    assign a_rsp_data  = r_a_rsp_data;
    assign b_rsp_valid = r_b_rsp_valid;
    assign b_rsp_data  = r_b_rsp_data;

endmodule

// File: tb/tb_sram_dual_port_scheduler.sv
// tb/tb_sram_dual_port_scheduler.sv - directed bench with macro model and rule-level scoreboard
module tb_sram_dual_port_scheduler;

    localparam int DELAY = 3;

    logic        clk;
    logic        rst;
    logic        a_valid, a_ready, a_we, a_rsp_valid;
    logic [3:0]  a_wmask;
    logic [7:0]  a_addr;
    logic [31:0] a_wdata, a_rsp_data;
    logic        b_valid, b_ready, b_we, b_rsp_valid;
    logic [3:0]  b_wmask;
    logic [7:0]  b_addr;
    logic [31:0] b_wdata, b_rsp_data;
    logic        sram_csb0, sram_web0, sram_csb1;
    logic [3:0]  sram_wmask0;
    logic [7:0]  sram_addr0, sram_addr1;
    logic [31:0] sram_din0, sram_dout0, sram_dout1;

    int checks = 0;
    int errors = 0;

    sram_dual_port_scheduler dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_wmask(a_wmask),
        .a_addr(a_addr), .a_wdata(a_wdata), .a_rsp_valid(a_rsp_valid), .a_rsp_data(a_rsp_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_wmask(b_wmask),
        .b_addr(b_addr), .b_wdata(b_wdata), .b_rsp_valid(b_rsp_valid), .b_rsp_data(b_rsp_data),
        .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
        .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0),
        .sram_csb1(sram_csb1), .sram_addr1(sram_addr1), .sram_dout1(sram_dout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Macro model: pins latched on the rising edge, array accessed on the falling edge
    logic [31:0] mem [256];
    logic        m_csb0, m_web0, m_csb1;
    logic [3:0]  m_wmask0;
    logic [7:0]  m_addr0, m_addr1;
    logic [31:0] m_din0;

    always @(posedge clk) begin
        m_csb0   = sram_csb0;
        m_web0   = sram_web0;
        m_wmask0 = sram_wmask0;
        m_addr0  = sram_addr0;
        m_din0   = sram_din0;
        m_csb1   = sram_csb1;
        m_addr1  = sram_addr1;
    end

    always @(negedge clk) begin
        if (m_csb0 === 1'b0 && m_web0 === 1'b0) begin
            for (int l = 0; l < 4; l++)
                if (m_wmask0[l]) mem[m_addr0][l*8 +: 8] = m_din0[l*8 +: 8];
        end
        if (m_csb0 === 1'b0 && m_web0 === 1'b1) sram_dout0 <= #DELAY mem[m_addr0];
        if (m_csb1 === 1'b0) sram_dout1 <= #DELAY mem[m_addr1];
    end

    function automatic logic [31:0] pattern(input logic [7:0] a);
        return {8'h5A, a, ~a, a};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: reference memory, priority bit and responses due three negedges after acceptance
    logic [31:0] ref_mem [256];
    logic        ex_av [4], ex_bv [4];
    logic [31:0] ex_ad [4], ex_bd [4];
    logic        e_csb0, e_web0, e_csb1;
    logic        prio_b;
    int          cyc = 0;

    always @(negedge clk) begin
        automatic int  s = cyc % 4;
        automatic int  t = (cyc + 3) % 4;
        automatic logic a_w, a_r, b_w, b_r, a_ok, b_ok;
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                ex_av[i] = 1'b0; ex_bv[i] = 1'b0; ex_ad[i] = '0; ex_bd[i] = '0;
            end
            e_csb0 = 1'b1; e_web0 = 1'b1; e_csb1 = 1'b1; prio_b = 1'b0;
            chk("rst_a_rsp_valid", a_rsp_valid, 0);
            chk("rst_b_rsp_valid", b_rsp_valid, 0);
            chk("rst_csb0", sram_csb0, 1);
            chk("rst_csb1", sram_csb1, 1);
        end else begin
            chk("sb_a_rsp_valid", a_rsp_valid, ex_av[s]);
            chk("sb_b_rsp_valid", b_rsp_valid, ex_bv[s]);
            if (ex_av[s]) chk("sb_a_rsp_data", a_rsp_data, ex_ad[s]);
            if (ex_bv[s]) chk("sb_b_rsp_data", b_rsp_data, ex_bd[s]);
            chk("sb_csb0", sram_csb0, e_csb0);
            chk("sb_web0", sram_web0, e_web0);
            chk("sb_csb1", sram_csb1, e_csb1);
            ex_av[s] = 1'b0;
            ex_bv[s] = 1'b0;
            a_w = a_valid & a_we;  a_r = a_valid & ~a_we;
            b_w = b_valid & b_we;  b_r = b_valid & ~b_we;
            if (a_w && b_w) begin
                a_ok = !prio_b;
                b_ok = prio_b;
                prio_b = !prio_b;
            end else begin
                a_ok = a_valid && !(a_r && b_w && a_addr == b_addr);
                b_ok = b_valid && !(b_r && a_w && a_addr == b_addr);
            end
            if (a_valid) chk("sb_a_ready", a_ready, a_ok);
            if (b_valid) chk("sb_b_ready", b_ready, b_ok);
            e_web0 = !((a_w && a_ok) || (b_w && b_ok));
            e_csb0 = e_web0 && !(a_r && b_r);
            e_csb1 = !((a_r && a_ok) || (b_r && b_ok));
            if (a_r && a_ok) begin ex_av[t] = 1'b1; ex_ad[t] = ref_mem[a_addr]; end
            if (b_r && b_ok) begin ex_bv[t] = 1'b1; ex_bd[t] = ref_mem[b_addr]; end
            for (int l = 0; l < 4; l++) begin
                if (a_w && a_ok && a_wmask[l]) ref_mem[a_addr][l*8 +: 8] = a_wdata[l*8 +: 8];
                if (b_w && b_ok && b_wmask[l]) ref_mem[b_addr][l*8 +: 8] = b_wdata[l*8 +: 8];
            end
        end
        cyc++;
    end

    task automatic drive(input logic av, input logic aw, input logic [3:0] am, input logic [7:0] aa,
                         input logic [31:0] ad, input logic bv, input logic bw, input logic [3:0] bm,
                         input logic [7:0] ba, input logic [31:0] bd);
        a_valid = av; a_we = aw; a_wmask = am; a_addr = aa; a_wdata = ad;
        b_valid = bv; b_we = bw; b_wmask = bm; b_addr = ba; b_wdata = bd;
    endtask

    task automatic idle();
        drive(0, 0, 4'h0, 8'h00, 32'h0, 0, 0, 4'h0, 8'h00, 32'h0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int ai, bi, na, nb, nboth;
        for (int i = 0; i < 256; i++) begin
            mem[i] = pattern(8'(i));
            ref_mem[i] = pattern(8'(i));
        end
        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_csb0", sram_csb0, 1);
        chk("reset_csb1", sram_csb1, 1);
        chk("reset_web0", sram_web0, 1);
        chk("reset_addr0", sram_addr0, 0);
        chk("reset_a_rsp_valid", a_rsp_valid, 0);

        // 1: move priority to B, start a read, then reset mid-flight
        drive(1, 1, 4'hF, 8'h01, 32'h1, 1, 1, 4'hF, 8'h02, 32'h2);
        step();
        drive(1, 0, 4'h0, 8'h50, 32'h0, 0, 0, 4'h0, 8'h00, 32'h0);
        step();
        idle();
        rst = 1'b1;
        #1;
        chk("t1_csb0_in_reset", sram_csb0, 1);
        chk("t1_csb1_in_reset", sram_csb1, 1);
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t1_no_rsp_after_reset", a_rsp_valid, 0);
        end
        drive(1, 1, 4'hF, 8'h03, 32'h3, 1, 1, 4'hF, 8'h04, 32'h4);
        #1;
        chk("t1_rr_a_ready", a_ready, 1);
        chk("t1_rr_b_ready", b_ready, 0);
        step();
        #1;
        chk("t1_rr_toggle_b_ready", b_ready, 1);
        step();
        idle();

        // 2: full write then read
        drive(1, 1, 4'hF, 8'h10, 32'hDEADBEEF, 0, 0, 4'h0, 8'h00, 32'h0);
        step();
        drive(1, 0, 4'h0, 8'h10, 32'h0, 0, 0, 4'h0, 8'h00, 32'h0);
        step();
        idle();
        step();
        chk("t2_rsp_not_early", a_rsp_valid, 0);
        step();
        chk("t2_rsp_valid", a_rsp_valid, 1);
        chk("t2_rsp_data", a_rsp_data, 32'hDEADBEEF);
        step();
        chk("t2_rsp_one_pulse", a_rsp_valid, 0);

        // 3: byte-lane write
        drive(1, 1, 4'b0001, 8'h10, 32'h000000AA, 0, 0, 4'h0, 8'h00, 32'h0);
        step();
        drive(1, 0, 4'h0, 8'h10, 32'h0, 0, 0, 4'h0, 8'h00, 32'h0);
        step();
        idle();
        step();
        step();
        chk("t3_rsp_valid", a_rsp_valid, 1);
        chk("t3_rsp_data", a_rsp_data, 32'hDEADBEAA);

        // 4: write-write contention with requesters holding until accepted
        ai = 0;
        bi = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 4'hF, 8'(8'h30 + ai), 32'hA0A00000 + 32'(ai),
                  1, 1, 4'hF, 8'(8'h40 + bi), 32'hB0B00000 + 32'(bi));
            #1;
            chk("t4_a_ready", a_ready, (i % 2 == 0) ? 1 : 0);
            chk("t4_b_ready", b_ready, (i % 2 == 1) ? 1 : 0);
            step();
            if (i % 2 == 0) ai++; else bi++;
        end
        drive(1, 0, 4'h0, 8'h30, 32'h0, 1, 0, 4'h0, 8'h40, 32'h0);
        step();
        drive(1, 0, 4'h0, 8'h31, 32'h0, 1, 0, 4'h0, 8'h41, 32'h0);
        step();
        idle();
        step();
        chk("t4_a0_data", a_rsp_data, 32'hA0A00000);
        chk("t4_b0_data", b_rsp_data, 32'hB0B00000);
        step();
        chk("t4_a1_data", a_rsp_data, 32'hA0A00001);
        chk("t4_b1_data", b_rsp_data, 32'hB0B00001);
        step();

        // 5: same-cycle same-address write beats read
        drive(1, 1, 4'hF, 8'h20, 32'h12345678, 1, 0, 4'h0, 8'h20, 32'h0);
        #1;
        chk("t5_a_ready", a_ready, 1);
        chk("t5_b_stalled", b_ready, 0);
        step();
        drive(0, 0, 4'h0, 8'h00, 32'h0, 1, 0, 4'h0, 8'h20, 32'h0);
        #1;
        chk("t5_b_retry_ready", b_ready, 1);
        step();
        idle();
        step();
        step();
        chk("t5_b_rsp_valid", b_rsp_valid, 1);
        chk("t5_b_rsp_data", b_rsp_data, 32'h12345678);
        step();

        // 6: back-to-back dual reads
        na = 0;
        nb = 0;
        nboth = 0;
        for (int i = 0; i < 11; i++) begin
            if (i < 8) begin
                drive(1, 0, 4'h0, 8'(8'h80 + i), 32'h0, 1, 0, 4'h0, 8'(8'hC0 + i), 32'h0);
                #1;
                chk("t6_a_ready", a_ready, 1);
                chk("t6_b_ready", b_ready, 1);
            end else begin
                idle();
            end
            step();
            if (a_rsp_valid) na++;
            if (b_rsp_valid) nb++;
            if (a_rsp_valid && b_rsp_valid) nboth++;
            if (i == 2) begin
                chk("t6_first_a_data", a_rsp_data, 32'h5A807F80);
                chk("t6_first_b_data", b_rsp_data, 32'h5AC03FC0);
            end
        end
        chk("t6_a_count", 32'(na), 8);
        chk("t6_b_count", 32'(nb), 8);
        chk("t6_paired_count", 32'(nboth), 8);

        repeat (3) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
